// File: rtl/float_add_arbiter_if.sv
// float_add_arbiter_if: bundles the requester, response and shared-adder streams
// of float_add_arbiter.
//   slave  : arbiter side (takes requests and adder results, drives adder operands and responses)
//   master : environment side (requesters, response sinks and the adder)
// Requester i occupies bits [i*SIZE +: SIZE] of req_a_tdata / req_b_tdata.
interface float_add_arbiter_if #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ*SIZE-1:0] req_a_tdata;
  logic [NUM_REQ*SIZE-1:0] req_b_tdata;
  logic [NUM_REQ-1:0]      req_tvalid;
  logic [NUM_REQ-1:0]      req_tready;
  logic [SIZE-1:0]         rsp_tdata;
  logic [NUM_REQ-1:0]      rsp_tvalid;
  logic [NUM_REQ-1:0]      rsp_tready;
  logic [SIZE-1:0]         add_a_tdata;
  logic [SIZE-1:0]         add_b_tdata;
  logic                    add_a_tvalid;
  logic                    add_b_tvalid;
  logic                    add_a_tready;
  logic                    add_b_tready;
  logic [SIZE-1:0]         add_result_tdata;
  logic                    add_result_tvalid;
  logic                    add_result_tready;

  modport slave (
    input  req_a_tdata, req_b_tdata, req_tvalid, rsp_tready,
    input  add_a_tready, add_b_tready, add_result_tdata, add_result_tvalid,
    output req_tready, rsp_tdata, rsp_tvalid,
    output add_a_tdata, add_b_tdata, add_a_tvalid, add_b_tvalid, add_result_tready
  );

  modport master (
    output req_a_tdata, req_b_tdata, req_tvalid, rsp_tready,
    output add_a_tready, add_b_tready, add_result_tdata, add_result_tvalid,
    input  req_tready, rsp_tdata, rsp_tvalid,
    input  add_a_tdata, add_b_tdata, add_a_tvalid, add_b_tvalid, add_result_tready
  );
endinterface

// File: rtl/float_add_arbiter.sv
// float_add_arbiter: shares one pipelined floating-point adder between NUM_REQ requesters.
// Round-robin grant with a lock while the adder stalls, an in-order tag FIFO that routes
// each adder result back to the requester that issued it.
// Ports:
//   aclk          clock, rising edge
//   aresetn       synchronous reset, active HIGH (asserted = 1)
//   bus           float_add_arbiter_if.slave: requester, response and adder streams
//   protocol_err  sticky: an adder result arrived with no outstanding tag
//   issue_count / stall_count (only with FLOAT_ADD_ARB_STATS_EN defined): 32-bit wrapping
//                 counters of issues and of cycles the adder operand stalled.
module float_add_arbiter #(
  parameter int unsigned SIZE         = 32,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  float_add_arbiter_if.slave bus,
  output logic               protocol_err
`ifdef FLOAT_ADD_ARB_STATS_EN
  ,
  output logic [31:0]        issue_count,
  output logic [31:0]        stall_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0] tag_mem_q [MAX_INFLIGHT];
  logic             protocol_err_q;

  logic [IDX_W-1:0] grant_idx, cand;
  logic             found;
  logic             issue, pop, stray, empty;
  logic [IDX_W-1:0] head_tag;

  // Grant: held while locked, else first valid requester at or after rr_ptr.
  always_comb begin
    grant_idx = rr_ptr_q;
    found     = 1'b0;
    cand      = '0;
    if (lock_q) begin
      grant_idx = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!found && bus.req_tvalid[cand]) begin
          grant_idx = cand;
          found     = 1'b1;
        end
      end
    end
  end

  // Operand path.
  always_comb begin
    bus.add_a_tdata = '0;
    bus.add_b_tdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        bus.add_a_tdata = bus.req_a_tdata[i*SIZE +: SIZE];
        bus.add_b_tdata = bus.req_b_tdata[i*SIZE +: SIZE];
      end
    end
    // The limit uses the registered count; a same-cycle pop does not free a slot.
    bus.add_a_tvalid = (lock_q || (|bus.req_tvalid)) && (count_q < CNT_W'(MAX_INFLIGHT));
    bus.add_b_tvalid = bus.add_a_tvalid;
    issue            = bus.add_a_tvalid && bus.add_a_tready && bus.add_b_tready;
    bus.req_tready   = issue ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Return path: purely combinational steering by the FIFO head tag.
  always_comb begin
    empty                 = (count_q == '0);
    head_tag              = tag_mem_q[rd_ptr_q];
    bus.rsp_tdata         = bus.add_result_tdata;
    if (empty) begin
      bus.rsp_tvalid        = '0;
      bus.add_result_tready = 1'b1;
    end else begin
      bus.rsp_tvalid        = NUM_REQ'(bus.add_result_tvalid) << head_tag;
      bus.add_result_tready = bus.rsp_tready[head_tag];
    end
    pop   = !empty && bus.add_result_tvalid && bus.add_result_tready;
    stray = empty && bus.add_result_tvalid;
  end

  // Next state.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    count_d    = count_q;
    if (issue) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      lock_d   = 1'b0;
    end else if (bus.add_a_tvalid) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end
    unique case ({issue, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      rr_ptr_q       <= '0;
      lock_q         <= 1'b0;
      lock_idx_q     <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      if (issue) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (stray) protocol_err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge aclk) begin
    if (issue) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign protocol_err = protocol_err_q;

`ifdef FLOAT_ADD_ARB_STATS_EN
  logic [31:0] issue_count_q, stall_count_q;

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      issue_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (issue)                          issue_count_q <= issue_count_q + 32'd1;
      if (bus.add_a_tvalid && !issue)     stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign issue_count = issue_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_float_add_arbiter.sv
// Self-checking bench for float_add_arbiter: a queue-based reference model is compared with
// the DUT every cycle, and directed scenarios pin issue/return orders to literal values.
module tb_float_add_arbiter;
  localparam int SIZE = 32;
  localparam int NREQ = 4;
  localparam int MAXI = 16;

  logic aclk = 1'b0;
  logic aresetn;
  logic protocol_err;
`ifdef FLOAT_ADD_ARB_STATS_EN
  logic [31:0] issue_count, stall_count;
`endif

  float_add_arbiter_if #(.SIZE(SIZE), .NUM_REQ(NREQ)) arb_bus ();

  float_add_arbiter #(.SIZE(SIZE), .NUM_REQ(NREQ), .MAX_INFLIGHT(MAXI)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .bus          (arb_bus),
    .protocol_err (protocol_err)
`ifdef FLOAT_ADD_ARB_STATS_EN
    ,
    .issue_count  (issue_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model state
  int          m_rr       = 0;
  bit          m_lock     = 0;
  int          m_lock_idx = 0;
  int          m_q[$];
  bit          m_perr     = 0;
  bit          m_live     = 0;
  logic [31:0] m_ic       = 0;
  logic [31:0] m_sc       = 0;
  int          issue_log[$];
  int          ret_log[$];

  int          g;
  int          head;
  bit          av, iss, empty, pop;
  logic [3:0]  exp_rv;
  logic        exp_art;

  always @(negedge aclk) begin
    g = -1;
    if (m_lock) g = m_lock_idx;
    else
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && arb_bus.req_tvalid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    if (g < 0) g = m_rr;
    av      = (m_lock || (arb_bus.req_tvalid != 0)) && (m_q.size() < MAXI);
    iss     = av && arb_bus.add_a_tready && arb_bus.add_b_tready;
    empty   = (m_q.size() == 0);
    head    = empty ? 0 : m_q[0];
    exp_rv  = (!empty && arb_bus.add_result_tvalid) ? 4'(1 << head) : 4'd0;
    exp_art = empty ? 1'b1 : arb_bus.rsp_tready[head];

    if (m_live) begin
      chk("add_a_tvalid", 64'(arb_bus.add_a_tvalid), 64'(av));
      chk("add_b_tvalid", 64'(arb_bus.add_b_tvalid), 64'(av));
      chk("req_tready", 64'(arb_bus.req_tready), iss ? 64'(1 << g) : 64'd0);
      if (av) begin
        chk("add_a_tdata", 64'(arb_bus.add_a_tdata), 64'(arb_bus.req_a_tdata[g*SIZE +: SIZE]));
        chk("add_b_tdata", 64'(arb_bus.add_b_tdata), 64'(arb_bus.req_b_tdata[g*SIZE +: SIZE]));
      end
      chk("rsp_tvalid", 64'(arb_bus.rsp_tvalid), 64'(exp_rv));
      chk("add_result_tready", 64'(arb_bus.add_result_tready), 64'(exp_art));
      if (exp_rv != 0) chk("rsp_tdata", 64'(arb_bus.rsp_tdata), 64'(arb_bus.add_result_tdata));
      chk("protocol_err", 64'(protocol_err), 64'(m_perr));
`ifdef FLOAT_ADD_ARB_STATS_EN
      chk("issue_count", 64'(issue_count), 64'(m_ic));
      chk("stall_count", 64'(stall_count), 64'(m_sc));
`endif
    end

    if (aresetn) begin
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_q.delete(); m_perr = 0;
      m_ic = 0; m_sc = 0; m_live = 1;
    end else begin
      pop = !empty && arb_bus.add_result_tvalid && exp_art;
      if (pop) begin
        ret_log.push_back(head);
        m_q.delete(0);
      end
      if (empty && arb_bus.add_result_tvalid) m_perr = 1;
      if (iss) m_ic = m_ic + 1;
      else if (av) m_sc = m_sc + 1;
      if (iss) begin
        m_q.push_back(g);
        issue_log.push_back(g);
        m_rr   = (g + 1) % NREQ;
        m_lock = 0;
      end else if (av) begin
        m_lock     = 1;
        m_lock_idx = g;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn                   = 1'b1;
    arb_bus.req_tvalid        = '0;
    arb_bus.add_result_tvalid = 1'b0;
    arb_bus.add_a_tready      = 1'b1;
    arb_bus.add_b_tready      = 1'b1;
    arb_bus.rsp_tready        = '1;
    step(2);
    aresetn = 1'b0;
    issue_log.delete();
    ret_log.delete();
  endtask

  task automatic check_log(string name, bit use_ret, int n,
                           int e0 = 0, int e1 = 0, int e2 = 0, int e3 = 0, int e4 = 0);
    int e[5];
    int got;
    e = '{e0, e1, e2, e3, e4};
    got = use_ret ? ret_log.size() : issue_log.size();
    chk({name, "_len"}, 64'(got), 64'(n));
    for (int i = 0; i < n && i < got; i++)
      chk(name, 64'(use_ret ? ret_log[i] : issue_log[i]), 64'(e[i]));
  endtask

  initial begin
    aresetn                  = 1'b1;
    arb_bus.req_tvalid       = '0;
    arb_bus.rsp_tready       = '1;
    arb_bus.add_a_tready     = 1'b1;
    arb_bus.add_b_tready     = 1'b1;
    arb_bus.add_result_tdata = 32'h4040_0000;
    arb_bus.add_result_tvalid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      arb_bus.req_a_tdata[i*SIZE +: SIZE] = 32'h3f80_0000 + 32'(i);
      arb_bus.req_b_tdata[i*SIZE +: SIZE] = 32'h4000_0000 + 32'(i);
    end

    // Reset state
    do_reset();
    chk("rst_req_tready", 64'(arb_bus.req_tready), 64'd0);
    chk("rst_add_a_tvalid", 64'(arb_bus.add_a_tvalid), 64'd0);
    chk("rst_rsp_tvalid", 64'(arb_bus.rsp_tvalid), 64'd0);
    chk("rst_add_result_tready", 64'(arb_bus.add_result_tready), 64'd1);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);

    // All four requesters valid, adder always ready
    arb_bus.req_tvalid = 4'hF;
    step(5);
    arb_bus.req_tvalid = 4'h0;
    check_log("rr_issue", 0, 5, 0, 1, 2, 3, 0);
    arb_bus.add_result_tvalid = 1'b1;
    step(5);
    arb_bus.add_result_tvalid = 1'b0;
    check_log("rr_return", 1, 5, 0, 1, 2, 3, 0);

    // Grant lock while the adder stalls
    do_reset();
    arb_bus.add_a_tready = 1'b0;
    arb_bus.req_tvalid   = 4'b0100;
    step(1);
    chk("lock_data0", 64'(arb_bus.add_a_tdata), 64'h3f80_0002);
    arb_bus.req_tvalid = 4'b0101;
    step(2);
    chk("lock_data1", 64'(arb_bus.add_a_tdata), 64'h3f80_0002);
    chk("lock_tready", 64'(arb_bus.req_tready), 64'd0);
    arb_bus.add_a_tready = 1'b1;
    #1;
    chk("lock_issue_tready", 64'(arb_bus.req_tready), 64'b0100);
    step(1);
    arb_bus.req_tvalid = 4'b0001;
    step(1);
    arb_bus.req_tvalid = 4'b0000;
    step(1);
    check_log("lock_issue", 0, 2, 2, 0);

    // In-flight limit with the result path stalled
    do_reset();
    arb_bus.rsp_tready = 4'h0;
    arb_bus.req_tvalid = 4'hF;
    step(20);
    chk("limit_issues", 64'(issue_log.size()), 64'd16);
    chk("limit_valid", 64'(arb_bus.add_a_tvalid), 64'd0);
    arb_bus.add_result_tvalid = 1'b1;
    arb_bus.rsp_tready        = 4'hF;
    #1;
    chk("limit_pop_ready", 64'(arb_bus.add_result_tready), 64'd1);
    chk("limit_pop_valid", 64'(arb_bus.add_a_tvalid), 64'd0);
    step(1);
    arb_bus.add_result_tvalid = 1'b0;
    #1;
    chk("limit_reopen", 64'(arb_bus.add_a_tvalid), 64'd1);
    step(1);
    arb_bus.req_tvalid = 4'h0;
    chk("limit_issues2", 64'(issue_log.size()), 64'd17);

    // Head-of-line blocking; reset here also discards the outstanding tags
    do_reset();
    arb_bus.req_tvalid = 4'b0010; step(1);
    arb_bus.req_tvalid = 4'b1000; step(1);
    arb_bus.req_tvalid = 4'b0010; step(1);
    arb_bus.req_tvalid = 4'b0000;
    check_log("hol_issue", 0, 3, 1, 3, 1);
    arb_bus.add_result_tvalid = 1'b1;
    arb_bus.rsp_tready        = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hol_rsp_tvalid", 64'(arb_bus.rsp_tvalid), 64'b0010);
      chk("hol_art", 64'(arb_bus.add_result_tready), 64'd0);
      step(1);
    end
    arb_bus.rsp_tready = 4'b1010;
    step(3);
    arb_bus.add_result_tvalid = 1'b0;
    step(1);
    check_log("hol_return", 1, 3, 1, 3, 1);

    // Stray result with an empty tag FIFO
    do_reset();
    arb_bus.add_result_tvalid = 1'b1;
    #1;
    chk("stray_art", 64'(arb_bus.add_result_tready), 64'd1);
    chk("stray_rsp_tvalid", 64'(arb_bus.rsp_tvalid), 64'd0);
    step(1);
    arb_bus.add_result_tvalid = 1'b0;
    step(3);
    chk("stray_sticky", 64'(protocol_err), 64'd1);
    do_reset();
    chk("stray_cleared", 64'(protocol_err), 64'd0);

`ifdef FLOAT_ADD_ARB_STATS_EN
    // Statistics counters
    arb_bus.req_tvalid   = 4'hF;
    arb_bus.add_a_tready = 1'b0;
    step(4);
    arb_bus.add_a_tready = 1'b1;
    step(10);
    arb_bus.req_tvalid = 4'h0;
    step(1);
    chk("stats_issue", 64'(issue_count), 64'd10);
    chk("stats_stall", 64'(stall_count), 64'd4);
    do_reset();
    chk("stats_issue_rst", 64'(issue_count), 64'd0);
    chk("stats_stall_rst", 64'(stall_count), 64'd0);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
